// File: rtl/blk_ceb414.sv
// rtl/blk_ceb414.sv - clock-mux select sequencer: gate, hold, flip select, hold, ungate.
// Optional two-flop request synchronizer enabled by MEMLIBC_CLK_SEL_CTRL_SYNC_EN.
module blk_ceb414 #(
  parameter int GATE_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sel_req,
  output logic mux_sel,
  output logic clk_en,
  output logic busy,
  output logic switch_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [7:0] GATE_LOAD   = 8'(GATE_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mux_sel_q, mux_sel_d;
  logic       clk_en_q, clk_en_d;
  logic       busy_q, busy_d;
  logic       switch_done_q, switch_done_d;
  logic       req_eff;

`ifdef MEMLIBC_CLK_SEL_CTRL_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = sel_req;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign req_eff = sync2_q;
`else
  assign req_eff = sel_req;
`endif

  // sel_req is only looked at in IDLE, so a request that bounces mid-sequence is ignored
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mux_sel_d     = mux_sel_q;
    clk_en_d      = clk_en_q;
    busy_d        = busy_q;
    switch_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_eff != mux_sel_q) begin
          state_d  = GATE;
          clk_en_d = 1'b0;
          busy_d   = 1'b1;
          cnt_d    = GATE_LOAD;
        end
      end
      GATE: begin
        if (cnt_q == 8'd0) begin
          mux_sel_d = ~mux_sel_q;
          cnt_d     = SETTLE_LOAD;
          state_d   = SETTLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) begin
          clk_en_d      = 1'b1;
          busy_d        = 1'b0;
          switch_done_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      mux_sel_q     <= 1'b0;
      clk_en_q      <= 1'b1;
      busy_q        <= 1'b0;
      switch_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mux_sel_q     <= mux_sel_d;
      clk_en_q      <= clk_en_d;
      busy_q        <= busy_d;
      switch_done_q <= switch_done_d;
    end
  end

  assign mux_sel     = mux_sel_q;
  assign clk_en      = clk_en_q;
  assign busy        = busy_q;
  assign switch_done = switch_done_q;

endmodule

// File: doc/blk_ceb414.md
# memlibc_memory_bist_assembly_rtl_tessent_clk_sel_ctrl

Sequencer that drives the select of the memory BIST assembly's 2:1 clock mux and the enable of the downstream clock gate, so the mux input changes only while the muxed clock is gated off. A change on the requested select level starts a fixed sequence: gate the clock, hold, flip the select, hold, ungate. It sits beside the clock mux in the BIST assembly and runs on one always-running clock; its `mux_sel` output feeds the mux `s` input.

## Interface
- `GATE_CYCLES`, default 4: cycles `clk_en` is held low before `mux_sel` flips; legal range 1..255.
- `SETTLE_CYCLES`, default 4: cycles after the flip before `clk_en` returns high; legal range 1..255.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `sel_req` input 1: requested mux select level; treated as a level, not a pulse.
- `mux_sel` output 1: registered select driven to the clock mux `s` input.
- `clk_en` output 1: registered enable for the downstream clock gate; 1 means the clock runs.
- `busy` output 1: high while a switch sequence is in progress.
- `switch_done` output 1: one-cycle pulse when a sequence completes.

## Operation
- Reset values: `mux_sel`=0, `clk_en`=1, `busy`=0, `switch_done`=0, state IDLE, counter 0.
- The counter is 8 bits wide. It is loaded with `GATE_CYCLES-1` or `SETTLE_CYCLES-1` and decremented once per cycle.
- State IDLE:
  - If the effective request differs from `mux_sel`, go to GATE. In the same update, set `clk_en`=0, `busy`=1 and load the counter with `GATE_CYCLES-1`.
  - Otherwise stay in IDLE.
- State GATE:
  - If the counter is 0, toggle `mux_sel`, load the counter with `SETTLE_CYCLES-1` and go to SETTLE.
  - Otherwise decrement the counter.
  - `clk_en` stays 0.
- State SETTLE:
  - If the counter is 0, set `clk_en`=1, `busy`=0 and `switch_done`=1, then go to IDLE.
  - Otherwise decrement the counter.
  - `clk_en` stays 0.
- `switch_done` is cleared on every update in which it is not being set.
- While not in IDLE, `sel_req` is ignored. When the sequence returns to IDLE, the request is re-evaluated on the next edge.
  - A request that toggled and returned during a sequence causes no further action.
  - A request that still differs from `mux_sel` starts a new sequence.
- `mux_sel` changes only while `clk_en`=0. The one exception is reset, which forces `mux_sel`=0 directly; the muxed clock domain is in reset at that point.
- Reset asserted mid-sequence aborts the sequence. All outputs take their reset values at that edge, and no `switch_done` pulse is produced.

## Timing
- Let E0 be the edge at which IDLE sees a mismatch.
  - After E0: `clk_en`=0 and `busy`=1.
  - After E0+`GATE_CYCLES`: `mux_sel` toggled.
  - After E0+`GATE_CYCLES`+`SETTLE_CYCLES`: `clk_en`=1, `busy`=0 and `switch_done`=1.
  - After E0+`GATE_CYCLES`+`SETTLE_CYCLES`+1: `switch_done`=0.
- `clk_en` is low for exactly `GATE_CYCLES`+`SETTLE_CYCLES` cycles. With the defaults that is 8 cycles.
- The earliest start of a back-to-back sequence is edge E0+`GATE_CYCLES`+`SETTLE_CYCLES`+1. On that edge `switch_done` falls and `clk_en` falls in the same update.
- All outputs are driven directly from flops; none has a combinational path from an input.

## Configuration
- Macro: `MEMLIBC_CLK_SEL_CTRL_SYNC_EN`.
- Defined: `sel_req` passes through a two-flop synchronizer, reset to 0, and the effective request is the second flop's output.
  - Detection latency from a `sel_req` change grows by 2 cycles.
  - A `sel_req` pulse shorter than one cycle may be missed.
- Undefined: the effective request is `sel_req` sampled directly, and E0 is the first edge at which the new level is stable.

## Test plan
- Reset, then hold `sel_req`=0 for 20 cycles: `mux_sel`=0, `clk_en`=1, `busy`=0 and `switch_done`=0 throughout.
- Defaults, raise `sel_req` to 1 at E0:
  - `clk_en` is low for cycles E0+1..E0+8.
  - `mux_sel` rises after E0+4.
  - `switch_done` is high only in the cycle after E0+8.
- `GATE_CYCLES`=1, `SETTLE_CYCLES`=1, toggle `sel_req` 1→0: `mux_sel` changes after E0+1, `clk_en` is low for 2 cycles, and `switch_done` pulses after E0+2.
- Defaults, `sel_req` 0→1→0 within the 8-cycle window: one sequence then a second.
  - The first sequence ends with `mux_sel`=1.
  - A second sequence starts at E0+9 and ends with `mux_sel`=0.
  - Two `switch_done` pulses in total.
- Defaults, assert `reset` at E0+5 (after the flip): `mux_sel`=0, `clk_en`=1 and `busy`=0 after that edge, and `switch_done` never pulses.
- With `MEMLIBC_CLK_SEL_CTRL_SYNC_EN` defined, repeat the second scenario: every event shifts later by 2 cycles, with `mux_sel` rising after E0+6 and `switch_done` high after E0+10.
